// File: rtl/uart_tx_arb_if.sv
// Requester / transmitter-side bundle for uart_tx_arb.
// slave: the arbiter's view; master: the requester/transmitter side.
interface uart_tx_arb_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GNT_W  = $clog2(NREQ)
);
    logic [NREQ*DATA_W-1:0] req_data_i;
    logic [NREQ-1:0]        req_v_i;
    logic [NREQ-1:0]        req_rdy_o;
    logic [DATA_W-1:0]      tx_data_o;
    logic                   tx_v_o;
    logic                   busy_o;
    logic [GNT_W-1:0]       gnt_id_o;

    modport slave (
        input  req_data_i, req_v_i,
        output req_rdy_o, tx_data_o, tx_v_o, busy_o, gnt_id_o
    );

    modport master (
        output req_data_i, req_v_i,
        input  req_rdy_o, tx_data_o, tx_v_o, busy_o, gnt_id_o
    );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one bit-serial UART transmitter between NREQ byte
// requesters. One clk_i cycle is one bit time. Frame completion is tracked
// locally because the transmitter has no busy output.
// Optional build macro UART_TX_ARB_PRIO_EN: fixed lowest-index priority
// instead of round-robin; timing is unchanged.
module uart_tx_arb #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAP    = 0,
    parameter int unsigned GNT_W  = $clog2(NREQ)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    uart_tx_arb_if.slave bus
);
    // Drain covers a whole frame the transmitter might still be sending.
    localparam int unsigned DRAIN_LEN = DATA_W + 2 + GAP;
    localparam int unsigned WAIT_LEN  = DATA_W + GAP;
    localparam int unsigned CNT_W     = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SEND  = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GNT_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [GNT_W-1:0]   gnt_q, gnt_d;
    logic               tx_v_q, tx_v_d;
    logic               busy_q, busy_d;
    logic [NREQ-1:0]    req_rdy;

    logic [GNT_W-1:0]   win;
    logic               win_vld;
    logic [DATA_W-1:0]  win_data;

    // Winner selection and its byte, evaluated every cycle.
    always_comb begin
        logic [GNT_W-1:0] idx;
        win      = '0;
        win_vld  = 1'b0;
        win_data = '0;
        idx      = '0;
`ifdef UART_TX_ARB_PRIO_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = GNT_W'(i);
            if (!win_vld && bus.req_v_i[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
`else
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = GNT_W'((32'(last_q) + k) % NREQ);
            if (!win_vld && bus.req_v_i[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (GNT_W'(i) == win) begin
                win_data = bus.req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state, counter and accept logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        req_rdy = '0;
        case (state_q)
            ST_DRAIN, ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (win_vld) begin
                    req_rdy = NREQ'(1) << win;
                    data_d  = win_data;
                    last_d  = win;
                    gnt_d   = win;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d   = CNT_W'(WAIT_LEN);
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_DRAIN;
                cnt_d   = CNT_W'(DRAIN_LEN);
            end
        endcase
        tx_v_d = (state_d == ST_SEND);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset waits out a possible in-flight frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CNT_W'(DRAIN_LEN);
            last_q  <= GNT_W'(NREQ - 1);
            data_q  <= '1;
            gnt_q   <= '0;
            tx_v_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            tx_v_q  <= tx_v_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.req_rdy_o = req_rdy;
    assign bus.tx_data_o = data_q;
    assign bus.tx_v_o    = tx_v_q;
    assign bus.busy_o    = busy_q;
    assign bus.gnt_id_o  = gnt_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a frame-level timeline model is
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_uart_tx_arb;
    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int GAP    = 0;
    localparam int FRAME  = DATA_W + 3 + GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arb #(.NREQ(NREQ), .DATA_W(DATA_W), .GAP(GAP)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Simple transmitter stand-in: start bit, DATA_W data bits LSB first, stop bit.
    logic [DATA_W+1:0] sh_q = '1;
    int                sh_cnt = 0;
    logic              line;
    always @(posedge clk) begin
        if (bus.tx_v_o) begin
            sh_q   <= {1'b1, bus.tx_data_o, 1'b0};
            sh_cnt <= DATA_W + 2;
        end else if (sh_cnt > 0) begin
            sh_q   <= sh_q >> 1;
            sh_cnt <= sh_cnt - 1;
        end
    end
    assign line = (sh_cnt > 0) ? sh_q[0] : 1'b1;

    // Arbitration rule from the specification.
    function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
`ifdef UART_TX_ARB_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
        return -1;
    endfunction

    // Timeline model: next idle cycle, expected start-pulse cycle, pointer, byte.
    int                m_ptr, m_idle_at, m_tx_at, m_gnt;
    logic [DATA_W-1:0] m_data;
    int                cyc_next = 0;
    int                acc_cyc[$];
    int                acc_id[$];
    int                txv_cyc[$];
    logic              line_hist [0:255];

    always @(negedge clk) begin
        int c;
        int w;
        logic [NREQ-1:0] e_rdy;
        if (rst) begin
            m_ptr     = NREQ - 1;
            m_idle_at = FRAME;
            m_tx_at   = -100;
            m_gnt     = 0;
            m_data    = '1;
            c         = -1;
            cyc_next  = 0;
        end else begin
            c        = cyc_next;
            cyc_next = cyc_next + 1;
        end
        w = -1;
        if (!rst && c >= m_idle_at) w = pick(m_ptr, bus.req_v_i);
        e_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
        chk("req_rdy_o", 32'(bus.req_rdy_o), 32'(e_rdy));
        chk("tx_v_o",    32'(bus.tx_v_o),    32'(c == m_tx_at));
        chk("busy_o",    32'(bus.busy_o),    32'(c < m_idle_at));
        chk("tx_data_o", 32'(bus.tx_data_o), 32'(m_data));
        chk("gnt_id_o",  32'(bus.gnt_id_o),  32'(m_gnt));
        if (c >= 0 && c < 256) line_hist[c] = line;
        if (c == m_tx_at) txv_cyc.push_back(c);
        if (w >= 0) begin
            acc_cyc.push_back(c);
            acc_id.push_back(w);
            m_data    = DATA_W'(bus.req_data_i >> (w * DATA_W));
            m_gnt     = w;
            m_ptr     = w;
            m_tx_at   = c + 1;
            m_idle_at = c + FRAME;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reset, load requests, then release; next negedge is cycle 0.
    task automatic start_phase(input logic [NREQ-1:0] v, input logic [NREQ*DATA_W-1:0] d);
        rst = 1'b1;
        bus.req_v_i    = v;
        bus.req_data_i = d;
        cycles(3);
        acc_cyc.delete();
        acc_id.delete();
        txv_cyc.delete();
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_line;
        bus.req_v_i    = '0;
        bus.req_data_i = '0;
        @(posedge clk);
        #2;

        // Persistent single requester, byte 0xA5, from reset release.
        start_phase(4'b0001, {8'h44, 8'h33, 8'h22, 8'hA5});
        cycles(30);
        chk("p1_first_accept", 32'(acc_cyc[0]), 32'd11);
        chk("p1_first_txv",    32'(txv_cyc[0]), 32'd12);
        chk("p1_txv_period",   32'(txv_cyc[1] - txv_cyc[0]), 32'd11);
        exp_line = 10'b1_1010_0101_0;
        for (int k = 0; k < 10; k++)
            chk($sformatf("p1_line_bit%0d", k), 32'(line_hist[13 + k]), 32'(exp_line[k]));

        // All four requesting: round-robin 0,1,2,3,0.
        start_phase(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        cycles(60);
        chk("p2_n_accept", 32'(acc_id.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p2_grant%0d", i), 32'(acc_id[i]), 32'(i % 4));
            chk($sformatf("p2_txv%0d", i),   32'(txv_cyc[i]), 32'(12 + 11 * i));
        end

        // 0101, then requester 1 joins mid-wait: 0,2,0,1,2.
        start_phase(4'b0101, {8'h44, 8'h33, 8'h22, 8'h11});
        cycles(36);
        bus.req_v_i = 4'b0111;
        cycles(30);
        chk("p3_grant0", 32'(acc_id[0]), 32'd0);
        chk("p3_grant1", 32'(acc_id[1]), 32'd2);
        chk("p3_grant2", 32'(acc_id[2]), 32'd0);
        chk("p3_grant3", 32'(acc_id[3]), 32'd1);
        chk("p3_grant4", 32'(acc_id[4]), 32'd2);

        // Reset four cycles into the wait of a frame from requester 2.
        start_phase(4'b0100, {8'h44, 8'h3C, 8'h22, 8'h11});
        cycles(17);
        chk("p4_pre_gnt",  32'(bus.gnt_id_o), 32'd2);
        chk("p4_pre_data", 32'(bus.tx_data_o), 32'hA0 ^ 32'h9C);
        rst = 1'b1;
        #1;
        chk("p4_async_data", 32'(bus.tx_data_o), 32'hFF);
        chk("p4_async_gnt",  32'(bus.gnt_id_o),  32'd0);
        chk("p4_async_busy", 32'(bus.busy_o),    32'd1);
        chk("p4_async_txv",  32'(bus.tx_v_o),    32'd0);
        #1;
        cycles(2);
        acc_cyc.delete();
        acc_id.delete();
        txv_cyc.delete();
        rst = 1'b0;
        cycles(30);
        chk("p4_first_txv", 32'(txv_cyc[0]), 32'd12);
        chk("p4_grant",     32'(acc_id[0]),  32'd2);

        // Requesters 1 and 2 constant.
        start_phase(4'b0110, {8'h44, 8'hC3, 8'h5A, 8'h11});
        cycles(50);
        chk("p5_n_accept", 32'(acc_id.size()), 32'd4);
`ifdef UART_TX_ARB_PRIO_EN
        for (int i = 0; i < 4; i++) chk($sformatf("p5_grant%0d", i), 32'(acc_id[i]), 32'd1);
        chk("p5_gnt_id", 32'(bus.gnt_id_o), 32'd1);
`else
        for (int i = 0; i < 4; i++) chk($sformatf("p5_grant%0d", i), 32'(acc_id[i]), 32'(1 + (i % 2)));
        chk("p5_gnt_id", 32'(bus.gnt_id_o), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one bit-serial UART transmitter between NREQ byte requesters.
- Arbitrates round-robin, presents the winner's byte on the transmitter's data/valid inputs, and holds off further grants until that frame finishes.
- The transmitter has no busy output, so frame completion is tracked by a local cycle counter.
- Runs on the transmitter's bit clock; one clk_i cycle is one bit time.

Parameters:
- NREQ, 4, number of requesters (must be >= 2).
- DATA_W, 8, byte width; must equal the transmitter's data width.
- GAP, 0, extra idle bit-times inserted after each frame's stop bit.
- GNT_W, $clog2(NREQ), width of the grant index (derived; not overridden).

Ports:
- clk_i  in  1  bit clock, shared with the transmitter.
- rst_i  in  1  reset, asynchronous, active-high.
- req_data_i  in  NREQ*DATA_W  requester bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_v_i  in  NREQ  requester valid bits.
- req_rdy_o  out  NREQ  accept strobes, one-hot or zero.
- tx_data_o  out  DATA_W  byte to the transmitter's data input.
- tx_v_o  out  1  one-cycle start pulse to the transmitter's valid input.
- busy_o  out  1  high whenever the state is not ST_IDLE.
- gnt_id_o  out  GNT_W  index of the most recently accepted requester.

Behaviour:
- Handshake rules:
  - A transfer occurs on a cycle where req_v_i[i] and req_rdy_o[i] are both high.
  - A requester holds valid and data stable until accepted.
  - Deasserting valid before acceptance is permitted; that request is then simply not served.
- Reset state (asynchronous on rst_i high):
  - state = ST_DRAIN, cnt = DATA_W+2+GAP, last = NREQ-1.
  - Data register = all-ones; tx_data_o = all-ones.
  - tx_v_o = 0, req_rdy_o = 0, busy_o = 1, gnt_id_o = 0.
- ST_DRAIN:
  - Purpose: the transmitter has no reset and may be mid-frame, so the block waits out a full frame.
  - cnt==0 -> ST_IDLE; otherwise cnt decrements.
  - Result: the first accept is possible DATA_W+3+GAP cycles after reset release.
- ST_IDLE:
  - Winner = first i with req_v_i[i] high, searching last+1, last+2, ... with modulo-NREQ wrap.
  - req_rdy_o[winner] is combinational and asserts in this same cycle.
  - On accept: latch the winner's byte into the data register, last <= winner, gnt_id_o <= winner, go to ST_SEND.
  - No valid requesters: stay in ST_IDLE, req_rdy_o = 0.
- ST_SEND:
  - tx_v_o = 1 for exactly this cycle.
  - Load cnt = DATA_W+GAP, go to ST_WAIT.
- ST_WAIT:
  - cnt==0 -> ST_IDLE; otherwise cnt decrements.
- tx_data_o timing:
  - Driven directly from the data register; changes only on accept.
  - It is therefore stable through the transmitter's start-bit cycle (SEND+1), where the byte is captured.
- Timing and latency:
  - Accept at cycle a -> tx_v_o at a+1.
  - Transmitter: start bit at a+2, data bits a+3..a+2+DATA_W, stop bit at a+3+DATA_W.
  - Controller next reaches ST_IDLE at a+DATA_W+3+GAP.
  - Back-to-back frame period = DATA_W+3+GAP cycles (11 at defaults).
- Edge cases:
  - Simultaneous requests: only one is granted per frame; the round-robin pointer guarantees each of k continuously-valid requesters is served within k frames.
  - Single persistent requester: served every frame.
  - Requests arriving in ST_DRAIN, ST_SEND or ST_WAIT are not accepted; req_rdy_o stays 0.
  - Reset mid-frame: returns immediately to ST_DRAIN with reset values; the partially sent frame is abandoned and the pointer is reset.
- Arithmetic: cnt is wide enough to hold DATA_W+2+GAP; all pointer arithmetic wraps modulo NREQ.

Optional Feature:
- Macro: UART_TX_ARB_PRIO_EN.
- Defined: fixed priority replaces round-robin; the lowest-index valid requester always wins and last is ignored. gnt_id_o is still updated.
- Undefined: round-robin as described in Behaviour.
- All timing and the ST_DRAIN behaviour are identical in both builds.

Test Plan:
- Reset release, req_v_i=0001 asserted at once -> req_rdy_o[0] first high on cycle 11 after release; tx_v_o high cycle 12; busy_o=1 throughout.
- req0 sends 0xA5 with the transmitter instantiated -> serial line shows 0 then 1,0,1,0,0,1,0,1 (LSB first), then 1; tx_data_o stays 0xA5 from accept until the next accept.
- req_v_i=1111 held constant, distinct bytes per requester -> grants 0,1,2,3,0 with tx_v_o pulses exactly 11 cycles apart.
- req_v_i=0101 held constant, then req1 asserted mid-WAIT -> grant order 0,2,0 before the new request; req1 is then served on the next frame where it is first after last.
- rst_i asserted 4 cycles into ST_WAIT -> outputs take reset values asynchronously; no tx_v_o pulse until DATA_W+3 cycles after release.
- UART_TX_ARB_PRIO_EN build with req_v_i=0110 constant -> every grant is index 1, gnt_id_o=1; requester 2 is never served.
